// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode encoding, FSM state
// encoding and the helper that tells which opcodes take the iterative path.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'h0;
    localparam logic [3:0] ALU_OR   = 4'h1;
    localparam logic [3:0] ALU_ADD  = 4'h2;
    localparam logic [3:0] ALU_XOR  = 4'h3;
    localparam logic [3:0] ALU_NOR  = 4'h4;
    localparam logic [3:0] ALU_SLL  = 4'h5;
    localparam logic [3:0] ALU_SUB  = 4'h6;
    localparam logic [3:0] ALU_SLT  = 4'h7;
    localparam logic [3:0] ALU_SRL  = 4'h8;
    localparam logic [3:0] ALU_SRA  = 4'h9;
    localparam logic [3:0] ALU_MUL  = 4'hA;
    localparam logic [3:0] ALU_DIVU = 4'hB;
    localparam logic [3:0] ALU_REMU = 4'hC;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // MUL/DIVU/REMU run through the shift-add / restoring-division datapath.
    function automatic logic is_iterative(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Issue/writeback bus of alu_mc.
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high; valid must not depend on ready, and a producer holding valid keeps
// its payload stable until that edge. Input side: in_valid/in_ready carry
// aluop/a/b. Output side: out_valid/out_ready carry result/zero/err.
interface alu_mc_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       aluop;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             err;

    modport master (
        output in_valid, aluop, a, b, out_ready,
        input  in_ready, out_valid, result, zero, err
    );

    modport slave (
        input  in_valid, aluop, a, b, out_ready,
        output in_ready, out_valid, result, zero, err
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiplier / restoring divider, one step per cycle for
// WIDTH cycles. hi holds the product accumulator or the partial remainder,
// lo holds the multiplier or the dividend/quotient, bop holds the shifting
// multiplicand or the divisor. result reflects the value after the step in
// progress, so the caller can capture it on the same edge as the last step.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             divzero
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    count_q;
    logic             active_q, is_mul_q, is_rem_q, divzero_q;
    logic [WIDTH-1:0] hi_q, lo_q, bop_q;
    logic [WIDTH-1:0] hi_n, lo_n, bop_n;
    logic [WIDTH:0]   rem_sh;

    // One multiply or division step computed from the current registers.
    always_comb begin
        rem_sh = {hi_q, lo_q[WIDTH-1]};
        hi_n   = hi_q;
        lo_n   = lo_q;
        bop_n  = bop_q;
        if (is_mul_q) begin
            if (lo_q[0]) hi_n = hi_q + bop_q;
            lo_n  = lo_q >> 1;
            bop_n = bop_q << 1;
        end else if (rem_sh >= {1'b0, bop_q}) begin
            // True difference is below 2^WIDTH, so the low bits are exact.
            hi_n = rem_sh[WIDTH-1:0] - bop_q;
            lo_n = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            hi_n = rem_sh[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Operand capture on start, then WIDTH steps while the counter runs down.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q   <= '0;
            active_q  <= 1'b0;
            is_mul_q  <= 1'b0;
            is_rem_q  <= 1'b0;
            divzero_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            bop_q     <= '0;
        end else if (start) begin
            count_q   <= CW'(WIDTH);
            active_q  <= 1'b1;
            is_mul_q  <= (op == ALU_MUL);
            is_rem_q  <= (op == ALU_REMU);
            divzero_q <= (op != ALU_MUL) && (b == '0);
            hi_q      <= '0;
            lo_q      <= a;
            bop_q     <= b;
        end else if (active_q) begin
            count_q <= count_q - 1'b1;
            hi_q    <= hi_n;
            lo_q    <= lo_n;
            bop_q   <= bop_n;
            if (count_q == CW'(1)) active_q <= 1'b0;
        end
    end

    assign done    = active_q && (count_q == CW'(1));
    assign result  = (is_mul_q || is_rem_q) ? hi_n : lo_n;
    assign divzero = divzero_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready on both sides. Single-cycle ops and illegal
// opcodes answer one cycle after acceptance; MUL/DIVU/REMU take WIDTH+1 cycles.
// Build option: define ALU_MULDIV_EN to include the iterative multiply/divide
// datapath; without it opcodes A-C are reported as illegal.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic   clk,
    input  logic   reset_n,
    alu_mc_if.slave bus,
    output state_t dbg_state
);
    localparam int SHW = $clog2(WIDTH);

    state_t           state_q, next_state;
    logic             accept, iter_op, load_single, load_iter;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] single_res, result_q, iter_result;
    logic             single_err, zero_q, err_q, iter_done, iter_divzero;

    assign sh          = bus.b[SHW-1:0];
    assign bus.in_ready = (state_q == S_IDLE) || (state_q == S_DONE && bus.out_ready);
    assign accept      = bus.in_valid && bus.in_ready;

`ifdef ALU_MULDIV_EN
    assign iter_op = is_iterative(bus.aluop);

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (accept && iter_op),
        .op      (bus.aluop),
        .a       (bus.a),
        .b       (bus.b),
        .done    (iter_done),
        .result  (iter_result),
        .divzero (iter_divzero)
    );
`else
    assign iter_op      = 1'b0;
    assign iter_done    = 1'b0;
    assign iter_result  = '0;
    assign iter_divzero = 1'b0;
`endif

    // Single-cycle operations; anything not handled here is illegal.
    always_comb begin
        single_res = '0;
        single_err = 1'b0;
        case (bus.aluop)
            ALU_AND: single_res = bus.a & bus.b;
            ALU_OR:  single_res = bus.a | bus.b;
            ALU_ADD: single_res = bus.a + bus.b;
            ALU_XOR: single_res = bus.a ^ bus.b;
            ALU_NOR: single_res = ~(bus.a | bus.b);
            ALU_SLL: single_res = bus.a << sh;
            ALU_SUB: single_res = bus.a - bus.b;
            ALU_SLT: single_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            ALU_SRL: single_res = bus.a >> sh;
            ALU_SRA: single_res = WIDTH'($signed(bus.a) >>> sh);
            default: single_err = 1'b1;
        endcase
    end

    // Next-state logic and load strobes for the output registers.
    always_comb begin
        next_state  = state_q;
        load_single = 1'b0;
        load_iter   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE && bus.out_ready) next_state = S_IDLE;
                if (accept) begin
                    if (iter_op) begin
                        next_state = S_BUSY;
                    end else begin
                        next_state  = S_DONE;
                        load_single = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                if (iter_done) begin
                    next_state = S_DONE;
                    load_iter  = 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= next_state;
    end

    // Output registers; they only change when a new result is captured.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else if (load_single) begin
            result_q <= single_res;
            zero_q   <= (single_res == '0);
            err_q    <= single_err;
        end else if (load_iter) begin
            result_q <= iter_result;
            zero_q   <= (iter_result == '0);
            err_q    <= iter_divzero;
        end
    end

    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.err       = err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc at WIDTH=32: reset, a vector table, streaming,
// backpressure, abort by reset, and random ops against a reference model.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W  = 32;
    localparam int EW = W + 2;   // {err, zero, result}

    logic   clk = 1'b0;
    logic   reset_n;
    state_t dbg_state;

    alu_mc_if #(.WIDTH(W)) bus ();

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [EW-1:0] ref_model(input logic [3:0] op, input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
        logic [W-1:0]   r;
        logic           e;
        int unsigned    s;
        logic [63:0]    p;
        r = '0;
        e = 1'b0;
        s = b % W;
        p = '0;
        case (op)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: r = a + b;
            4'h3: r = a ^ b;
            4'h4: r = ~(a | b);
            4'h5: r = a << s;
            4'h6: r = a - b;
            4'h7: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'h8: r = a >> s;
            4'h9: r = W'(int'(a) >>> s);
`ifdef ALU_MULDIV_EN
            4'hA: begin p = {32'b0, a} * {32'b0, b}; r = p[W-1:0]; end
            4'hB: if (b == 0) begin r = '1; e = 1'b1; end else r = a / b;
            4'hC: if (b == 0) begin r = a;  e = 1'b1; end else r = a % b;
`endif
            default: e = 1'b1;
        endcase
        return {e, (r == '0), r};
    endfunction

    function automatic int exp_lat(input logic [3:0] op);
`ifdef ALU_MULDIV_EN
        if (op >= 4'hA && op <= 4'hC) return W + 1;
`endif
        return 1;
    endfunction

    // ---------------- driver ----------------
    // Issue one op with out_ready low, measure latency, compare, optionally hold
    // backpressure for 'hold' cycles, then consume the result.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [EW-1:0] exp, input int elat, input int hold, input string name);
        int            waits;
        int            lat;
        logic          busy_bad;
        logic [EW-1:0] got, want;
        exp_q.push_back(exp);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.aluop     = op;
        bus.a         = a;
        bus.b         = b;
        waits = 0;
        while (!bus.in_ready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (!bus.in_ready) begin
            check({name, " accept timeout"}, 64'(bus.in_ready), 64'd1);
            bus.in_valid = 1'b0;
            void'(exp_q.pop_front());
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.aluop    = 4'($urandom);
        bus.a        = $urandom;
        bus.b        = $urandom;
        lat      = 1;
        busy_bad = 1'b0;
        @(negedge clk);
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) busy_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(elat));
        if (elat > 1) check({name, " in_ready while busy"}, 64'(busy_bad), 64'd0);
        got  = {bus.err, bus.zero, bus.result};
        want = exp_q.pop_front();
        check({name, " {err,zero,result}"}, 64'(got), 64'(want));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, " held {valid,in_ready,err,zero,result}"},
                  64'({bus.out_valid, bus.in_ready, bus.err, bus.zero, bus.result}),
                  64'({1'b1, 1'b0, want}));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         zero;
        logic         err;
        int           lat;
        int           hold;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] res, input logic err, input int lat, input int hold);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res;
        v.zero = (res == '0); v.err = err; v.lat = lat; v.hold = hold;
        vecs.push_back(v);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0]    r_op;
        logic [W-1:0]  r_a, r_b;
        logic          seen;

        reset_n       = 1'b0;
        bus.in_valid  = 1'b1;
        bus.aluop     = ALU_ADD;
        bus.a         = 32'd5;
        bus.b         = 32'd6;
        bus.out_ready = 1'b0;

        // Reset held 3 cycles with in_valid high.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset out_valid", 64'(bus.out_valid), 64'd0);
            check("reset result", 64'(bus.result), 64'd0);
        end
        reset_n      = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post-reset in_ready", 64'(bus.in_ready), 64'd1);
        check("post-reset state", 64'(dbg_state), 64'(S_IDLE));
        check("post-reset {zero,err}", 64'({bus.zero, bus.err}), 64'd0);

        // ADD streaming with out_ready held high.
        exp_q.push_back({1'b0, 1'b0, 32'h8000_0000});
        exp_q.push_back({1'b0, 1'b1, 32'h0000_0000});
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.aluop     = ALU_ADD;
        bus.a         = 32'h7FFF_FFFF;
        bus.b         = 32'd1;
        @(posedge clk);
        #1;
        bus.a = 32'hFFFF_FFFF;
        @(negedge clk);
        check("stream#1 valid/in_ready", 64'({bus.out_valid, bus.in_ready}), 64'b11);
        check("stream#1 {err,zero,result}", 64'({bus.err, bus.zero, bus.result}), 64'(exp_q.pop_front()));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("stream#2 valid", 64'(bus.out_valid), 64'd1);
        check("stream#2 {err,zero,result}", 64'({bus.err, bus.zero, bus.result}), 64'(exp_q.pop_front()));
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("stream drained valid", 64'(bus.out_valid), 64'd0);

        // Directed table.
        add_vec(ALU_SLT, 32'hFFFF_FFFF, 32'd1,        32'd1,         1'b0, 1, 0);
        add_vec(ALU_SRA, 32'h8000_0000, 32'h24,       32'hF800_0000, 1'b0, 1, 0);
        add_vec(4'hE,    32'd3,         32'd4,        32'd0,         1'b1, 1, 0);
        add_vec(4'hF,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,        1'b1, 1, 0);
        add_vec(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1, 0);
        add_vec(ALU_OR,  32'h0F0F_0000, 32'h00F0_00F0, 32'h0FFF_00F0, 1'b0, 1, 0);
        add_vec(ALU_XOR, 32'hFFFF_0000, 32'h0FF0_0FF0, 32'hF00F_0FF0, 1'b0, 1, 0);
        add_vec(ALU_NOR, 32'd0,         32'd0,        32'hFFFF_FFFF, 1'b0, 1, 0);
        add_vec(ALU_SLL, 32'd1,         32'h21,       32'd2,         1'b0, 1, 0);
        add_vec(ALU_SUB, 32'd0,         32'd1,        32'hFFFF_FFFF, 1'b0, 1, 0);
        add_vec(ALU_SUB, 32'd5,         32'd5,        32'd0,         1'b0, 1, 0);
        add_vec(ALU_SRL, 32'h8000_0000, 32'h3F,       32'd1,         1'b0, 1, 0);
        add_vec(ALU_ADD, 32'd2,         32'd3,        32'd5,         1'b0, 1, 5);
`ifdef ALU_MULDIV_EN
        add_vec(ALU_MUL,  32'h1_0000, 32'h1_0001, 32'h0001_0000, 1'b0, W + 1, 5);
        add_vec(ALU_DIVU, 32'd100,    32'd7,      32'd14,        1'b0, W + 1, 0);
        add_vec(ALU_REMU, 32'd100,    32'd7,      32'd2,         1'b0, W + 1, 0);
        add_vec(ALU_DIVU, 32'd5,      32'd0,      32'hFFFF_FFFF, 1'b1, W + 1, 0);
        add_vec(ALU_REMU, 32'd9,      32'd0,      32'd9,         1'b1, W + 1, 0);
`else
        add_vec(ALU_MUL,  32'h1_0000, 32'h1_0001, 32'd0, 1'b1, 1, 5);
        add_vec(ALU_DIVU, 32'd100,    32'd7,      32'd0, 1'b1, 1, 0);
        add_vec(ALU_REMU, 32'd100,    32'd7,      32'd0, 1'b1, 1, 0);
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b,
                   {vecs[i].err, vecs[i].zero, vecs[i].res},
                   vecs[i].lat, vecs[i].hold, $sformatf("vec%0d op%0h", i, vecs[i].op));
        end

        // Abort: reset in the middle of a DIVU, then check a fresh ADD.
        bus.in_valid = 1'b1;
        bus.aluop    = ALU_DIVU;
        bus.a        = 32'd100;
        bus.b        = 32'd7;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("abort no out_valid", 64'(seen), 64'd0);
        run_op(ALU_ADD, 32'd40, 32'd2, ref_model(ALU_ADD, 32'd40, 32'd2), 1, 0, "post-abort add");

        // Random ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            r_op = 4'($urandom_range(0, 15));
            r_a  = $urandom;
            r_b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
            run_op(r_op, r_a, r_b, ref_model(r_op, r_a, r_b), exp_lat(r_op),
                   $urandom_range(0, 2), $sformatf("rand%0d op%0h", i, r_op));
        end

        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
